// File: rtl/sd_phy_pkg.sv
// Shared definitions for the host-side SD PHY: DAT bus width, nibble order, lock default.
package sd_phy_pkg;
    localparam int SD_BUS_W            = 4;
    localparam int DEFAULT_LOCK_CYCLES = 16;

    // Which half of a byte is on DAT in a bus phase: high nibble while the bus clock is high.
    typedef enum logic {
        NIB_LO = 1'b0,
        NIB_HI = 1'b1
    } nibble_e;

    // Select one nibble of a byte; bit 3 of the result lands on DAT[3].
    function automatic logic [SD_BUS_W-1:0] pick_nibble(input logic [7:0] b, input nibble_e sel);
        return (sel == NIB_HI) ? b[7:4] : b[3:0];
    endfunction
endpackage

// File: rtl/sd_clk_gen.sv
// SD bus clock generator: lock counter, runtime divider, clean gating, edge strobes.
module sd_clk_gen
    import sd_phy_pkg::*;
#(
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] clk_div,
    input  logic       clk_en,
    output logic       locked,
    output logic       phy_clk,
    output logic       posedge_stb,
    output logic       negedge_stb,
    output logic       phase_end
);
    localparam int                LOCK_W    = $clog2(LOCK_CYCLES) + 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic [LOCK_W-1:0] lock_cnt;
    logic [7:0]        div_cnt;
    logic [7:0]        div_q;
    logic              run;

    // Lock counter counts up after reset and saturates; saturation is the sticky lock flag.
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_LAST) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
        end
    end

    assign locked = (lock_cnt == LOCK_LAST);

    // A high phase always runs to completion, so dropping the enable gives one clean fall.
    assign run       = locked && (clk_en || phy_clk);
    // div_q holds the half period for the running phase; a new divider only lands at a phase end.
    assign phase_end = run && (div_cnt == div_q);

    // Divider, bus clock toggle and strobes that coincide with the output change.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            div_q       <= '0;
            phy_clk     <= 1'b0;
            posedge_stb <= 1'b0;
            negedge_stb <= 1'b0;
        end else begin
            posedge_stb <= phase_end && !phy_clk;
            negedge_stb <= phase_end && phy_clk;
            if (phase_end) begin
                div_cnt <= '0;
                div_q   <= clk_div;
                phy_clk <= !phy_clk;
            end else if (run) begin
                div_cnt <= div_cnt + 8'd1;
            end else begin
                // Parked low: restart counts a full low phase with the current divider.
                div_cnt <= '0;
                div_q   <= clk_div;
            end
        end
    end
endmodule

// File: rtl/sd_host_platform_cocotb.sv
// Host-side SD PHY: bus clock generation plus 4-bit DDR data and CMD retiming to the bus clock.
module sd_host_platform_cocotb
    import sd_phy_pkg::*;
#(
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    output logic                o_locked,
    input  logic [7:0]          i_clk_div,
    input  logic                i_clk_en,
    output logic                o_posedge_stb,
    output logic                o_negedge_stb,
    input  logic                i_sd_cmd_dir,
    input  logic                i_sd_cmd_out,
    output logic                o_sd_cmd_in,
    input  logic                i_sd_data_dir,
    input  logic [7:0]          i_sd_data_out,
    output logic [7:0]          o_sd_data_in,
    output logic                o_sd_data_stb,
    output logic                o_phy_clk,
    inout  wire                 io_phy_sd_cmd,
    inout  wire  [SD_BUS_W-1:0] io_phy_sd_data
);
    logic                phase_end;
    logic [7:0]          tx_byte;
    logic [SD_BUS_W-1:0] rx_hi;
    logic                cmd_q;
    logic [SD_BUS_W-1:0] data_drive;

    sd_clk_gen #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .clk_div     (i_clk_div),
        .clk_en      (i_clk_en),
        .locked      (o_locked),
        .phy_clk     (o_phy_clk),
        .posedge_stb (o_posedge_stb),
        .negedge_stb (o_negedge_stb),
        .phase_end   (phase_end)
    );

    // Data/CMD datapath: every capture happens in the last clk of a phase, just before the toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte       <= '0;
            rx_hi         <= '0;
            cmd_q         <= 1'b1;
            o_sd_cmd_in   <= 1'b1;
            o_sd_data_in  <= '0;
            o_sd_data_stb <= 1'b0;
        end else begin
            o_sd_data_stb <= phase_end && !o_phy_clk;
            if (phase_end) begin
                if (o_phy_clk) begin
                    // Ending high phase: keep the device's high nibble, launch CMD for the next period.
                    rx_hi <= io_phy_sd_data;
                    cmd_q <= i_sd_cmd_out;
                end else begin
                    // Ending low phase: the rise starts a new byte out and completes the byte in.
                    tx_byte      <= i_sd_data_out;
                    o_sd_data_in <= {rx_hi, io_phy_sd_data};
                    o_sd_cmd_in  <= io_phy_sd_cmd;
                end
            end
        end
    end

    // Drive values come only from bus-edge registers, so they change only at bus edges.
    assign data_drive     = pick_nibble(tx_byte, o_phy_clk ? NIB_HI : NIB_LO);
    assign io_phy_sd_data = i_sd_data_dir ? data_drive : 'z;
    assign io_phy_sd_cmd  = i_sd_cmd_dir ? cmd_q : 1'bz;
endmodule

// File: tb/tb_sd_host_platform_cocotb.sv
// Self-checking bench for the host SD PHY with a bus-level device model.
module tb_sd_host_platform_cocotb;
    import sd_phy_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       o_locked;
    logic [7:0] i_clk_div;
    logic       i_clk_en;
    logic       o_posedge_stb;
    logic       o_negedge_stb;
    logic       i_sd_cmd_dir;
    logic       i_sd_cmd_out;
    logic       o_sd_cmd_in;
    logic       i_sd_data_dir;
    logic [7:0] i_sd_data_out;
    logic [7:0] o_sd_data_in;
    logic       o_sd_data_stb;
    logic       o_phy_clk;
    wire        sd_cmd;
    wire  [3:0] sd_data;

    logic       dev_cmd_en;
    logic       dev_cmd;
    logic       dev_data_en;
    logic [3:0] dev_data;

    assign sd_cmd  = dev_cmd_en ? dev_cmd : 1'bz;
    assign sd_data = dev_data_en ? dev_data : 4'bz;

    always #5 clk = ~clk;

    sd_host_platform_cocotb dut (
        .clk            (clk),
        .rst            (rst),
        .o_locked       (o_locked),
        .i_clk_div      (i_clk_div),
        .i_clk_en       (i_clk_en),
        .o_posedge_stb  (o_posedge_stb),
        .o_negedge_stb  (o_negedge_stb),
        .i_sd_cmd_dir   (i_sd_cmd_dir),
        .i_sd_cmd_out   (i_sd_cmd_out),
        .o_sd_cmd_in    (o_sd_cmd_in),
        .i_sd_data_dir  (i_sd_data_dir),
        .i_sd_data_out  (i_sd_data_out),
        .o_sd_data_in   (o_sd_data_in),
        .o_sd_data_stb  (o_sd_data_stb),
        .o_phy_clk      (o_phy_clk),
        .io_phy_sd_cmd  (sd_cmd),
        .io_phy_sd_data (sd_data)
    );

    int         checks = 0;
    int         errors = 0;

    // Bus observer / device model state.
    logic       prev_phy = 1'b0;
    bit         rise;
    bit         fall;
    int         run_len = 0;
    int         phase_q[$];
    logic [7:0] dev_q[$];
    logic [3:0] last_nib = 4'h0;
    logic [3:0] dev_hi = 4'h0;
    logic       prev_dir = 1'b0;
    int         strobe_err = 0;
    int         glitch_err = 0;
    bit         rx_mode = 1'b0;
    bit         rx_valid = 1'b0;
    logic [7:0] rx_cur = 8'h00;
    logic [7:0] rx_q[$];

    logic [7:0] tx_exp[$];
    int         lock_early;
    int         n;
    logic       seed;
    logic       b;
    logic       c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clk: sample #2 after the edge, then update the bus-level model.
    task automatic tick();
        logic in_rst;
        in_rst = rst;
        @(posedge clk);
        #2;
        rise = (prev_phy == 1'b0) && (o_phy_clk == 1'b1);
        fall = (prev_phy == 1'b1) && (o_phy_clk == 1'b0);
        if (in_rst) begin
            rise    = 1'b0;
            fall    = 1'b0;
            run_len = 1;
        end else begin
            if (o_posedge_stb !== rise || o_negedge_stb !== fall || o_sd_data_stb !== rise)
                strobe_err++;
            if (rise || fall) begin
                phase_q.push_back(run_len);
                run_len = 1;
            end else begin
                run_len++;
            end
            // Device: high nibble is what DAT held through the high phase, byte completes at the rise.
            if (fall) dev_hi = last_nib;
            if (rise) dev_q.push_back({dev_hi, last_nib});
            if (!rise && !fall && prev_dir && i_sd_data_dir && sd_data !== last_nib) glitch_err++;
            // Device transmitter: one byte per bus period, host reports it at the following rise.
            if (rx_mode && rise) begin
                if (rx_valid) check("rx_byte", o_sd_data_in, rx_cur);
                rx_cur   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom);
                rx_valid = 1'b1;
            end
            if (rx_mode) dev_data = o_phy_clk ? rx_cur[7:4] : rx_cur[3:0];
        end
        prev_phy = o_phy_clk;
        last_nib = sd_data;
        prev_dir = i_sd_data_dir;
    endtask

    task automatic wait_edge(input string tag, input bit want_rise);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            tick();
            got = want_rise ? rise : fall;
        end
        check(tag, got, 1);
    endtask

    initial begin
        rst = 1'b1; i_clk_div = 8'd0; i_clk_en = 1'b0;
        i_sd_cmd_dir = 1'b0; i_sd_cmd_out = 1'b1;
        i_sd_data_dir = 1'b0; i_sd_data_out = 8'h00;
        dev_cmd_en = 1'b0; dev_cmd = 1'b1; dev_data_en = 1'b0; dev_data = 4'h0;
        seed = 1'($urandom);

        // Reset values, then lock timing with the bus clock disabled.
        tick();
        check("rst_locked", o_locked, 0);
        check("rst_phy_clk", o_phy_clk, 0);
        check("rst_pos_stb", o_posedge_stb, 0);
        check("rst_neg_stb", o_negedge_stb, 0);
        check("rst_cmd_in", o_sd_cmd_in, 1);
        check("rst_data_in", o_sd_data_in, 0);
        check("rst_data_stb", o_sd_data_stb, 0);
        rst = 1'b0;
        lock_early = 0;
        for (int k = 1; k < 15; k++) begin
            tick();
            if (o_locked !== 1'b0 || o_phy_clk !== 1'b0) lock_early++;
        end
        check("lock_early", lock_early, 0);
        tick();
        check("lock_at_clk16", o_locked, 1);
        repeat (10) tick();
        check("parked_no_en", o_phy_clk, 0);
        check("lock_sticky", o_locked, 1);

        // Divider 3: 4 clk per phase, strobes coincident with toggles.
        i_clk_div = 8'd3; i_clk_en = 1'b1;
        wait_edge("t2_first_rise", 1);
        phase_q.delete();
        repeat (3) begin
            wait_edge("t2_fall", 0);
            wait_edge("t2_rise", 1);
        end
        check("t2_nphases", phase_q.size(), 6);
        for (int i = 0; i < phase_q.size(); i++) check("t2_phase_len", phase_q[i], 4);
        check("t2_strobes", strobe_err, 0);

        // Tx loopback: directed bytes, then random bytes under a randomly changing divider.
        i_sd_data_dir = 1'b1;
        tx_exp = {8'hA5, 8'h3C, 8'hFF, 8'h00};
        repeat (8) tx_exp.push_back(8'($urandom));
        i_sd_data_out = tx_exp[0];
        wait_edge("t3_sync", 1);
        dev_q.delete();
        for (int i = 1; i <= tx_exp.size(); i++) begin
            i_sd_data_out = (i < tx_exp.size()) ? tx_exp[i] : 8'h00;
            if (i >= 4) i_clk_div = 8'($urandom_range(4, 0));
            wait_edge("t3_rise", 1);
        end
        check("t3_count", dev_q.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size() && i < dev_q.size(); i++) check("t3_tx_byte", dev_q[i], tx_exp[i]);
        check("t3_glitch", glitch_err, 0);

        // Rx: device drives 0x96 first, then random bytes, ending with 0x5A.
        i_sd_data_dir = 1'b0; dev_data_en = 1'b1; i_clk_div = 8'd1;
        rx_q = {8'h96};
        repeat (6) rx_q.push_back(8'($urandom));
        rx_q.push_back(8'h5A);
        rx_valid = 1'b0; rx_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_edge("t4_rise", 1);
            if (i >= 2) i_clk_div = 8'($urandom_range(3, 0));
        end
        rx_mode = 1'b0; dev_data_en = 1'b0;
        check("t4_strobes", strobe_err, 0);

        // CMD out: registered at the fall, held through the rise.
        i_clk_div = 8'd2; i_sd_cmd_dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 1'(i & 1) ^ seed;
            wait_edge("cmd_rise", 1);
            i_sd_cmd_out = b;
            wait_edge("cmd_fall", 0);
            check("cmd_tx_at_fall", sd_cmd, b);
            i_sd_cmd_out = ~b;
            wait_edge("cmd_rise_hold", 1);
            check("cmd_tx_at_rise", sd_cmd, b);
        end

        // CMD in: device value during the low phase appears with the rise.
        i_sd_cmd_dir = 1'b0; dev_cmd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c = (i == 3) ? 1'b0 : (1'(i & 1) ^ seed);
            wait_edge("cmdrx_fall", 0);
            dev_cmd = c;
            wait_edge("cmdrx_rise", 1);
            check("cmd_rx", o_sd_cmd_in, c);
        end
        dev_cmd_en = 1'b0; i_sd_cmd_dir = 1'b1; i_sd_cmd_out = 1'b0;

        // Divider 3 -> 0 in the middle of a high phase.
        i_clk_div = 8'd3; i_sd_data_dir = 1'b1;
        wait_edge("t5_rise_a", 1);
        wait_edge("t5_rise_b", 1);
        phase_q.delete();
        tick();
        i_clk_div = 8'd0;
        repeat (7) tick();
        check("t5_nphases", phase_q.size(), 5);
        check("t5_high_len", (phase_q.size() > 0) ? phase_q[0] : -1, 4);
        for (int i = 1; i < phase_q.size(); i++) check("t5_fast_len", phase_q[i], 1);
        check("t5_strobes", strobe_err, 0);

        // Enable dropped mid-high: one clean fall, then parked low.
        i_clk_div = 8'd3;
        wait_edge("t6_rise_a", 1);
        wait_edge("t6_rise_b", 1);
        phase_q.delete();
        tick();
        i_clk_en = 1'b0;
        repeat (20) tick();
        check("t6_one_fall", phase_q.size(), 1);
        check("t6_high_len", (phase_q.size() > 0) ? phase_q[0] : -1, 4);
        check("t6_parked", o_phy_clk, 0);

        // Enable dropped mid-low: freeze, then a full low phase before the first rise.
        i_clk_en = 1'b1;
        wait_edge("t6_rise_c", 1);
        wait_edge("t6_fall_c", 0);
        tick();
        i_clk_en = 1'b0;
        phase_q.delete();
        repeat (6) tick();
        check("t6_frozen_low", o_phy_clk, 0);
        check("t6_no_toggle", phase_q.size(), 0);
        i_clk_en = 1'b1;
        for (n = 1; n <= 50; n++) begin
            tick();
            if (rise) break;
        end
        check("t6_restart_low_len", n, 4);

        // Reset in the middle of a byte.
        i_sd_data_out = 8'hC3;
        wait_edge("t7_rise_a", 1);
        wait_edge("t7_rise_b", 1);
        check("t7_self_loopback", o_sd_data_in, 8'hC3);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_locked", o_locked, 0);
        check("mrst_phy_clk", o_phy_clk, 0);
        check("mrst_pos_stb", o_posedge_stb, 0);
        check("mrst_neg_stb", o_negedge_stb, 0);
        check("mrst_cmd_in", o_sd_cmd_in, 1);
        check("mrst_data_in", o_sd_data_in, 0);
        check("mrst_data_stb", o_sd_data_stb, 0);
        check("mrst_data_bus", sd_data, 0);
        rst = 1'b0;
        tick();
        check("final_strobes", strobe_err, 0);
        check("final_glitch", glitch_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
